// File: rtl/spell_mem_arbiter_if.sv
// Bus bundle for spell_mem_arbiter: two requester ports (A = CPU, B = debug),
// the shared peripheral bus, and the arbitration status outputs.
interface spell_mem_arbiter_if;
  logic       a_select;
  logic       a_write;
  logic [7:0] a_addr;
  logic [7:0] a_data_in;
  logic [7:0] a_data_out;
  logic       a_data_ready;

  logic       b_select;
  logic       b_write;
  logic [7:0] b_addr;
  logic [7:0] b_data_in;
  logic [7:0] b_data_out;
  logic       b_data_ready;

  logic       mem_select;
  logic       mem_write;
  logic [7:0] mem_addr;
  logic [7:0] mem_data_out;
  logic [7:0] mem_data_in;
  logic       mem_data_ready;

  logic [1:0] grant;
  logic       timeout_err;

  // Arbiter side.
  modport slave (
    input  a_select, a_write, a_addr, a_data_in,
    output a_data_out, a_data_ready,
    input  b_select, b_write, b_addr, b_data_in,
    output b_data_out, b_data_ready,
    output mem_select, mem_write, mem_addr, mem_data_out,
    input  mem_data_in, mem_data_ready,
    output grant, timeout_err
  );

  // Environment side: both requesters plus the peripheral.
  modport master (
    output a_select, a_write, a_addr, a_data_in,
    input  a_data_out, a_data_ready,
    output b_select, b_write, b_addr, b_data_in,
    input  b_data_out, b_data_ready,
    input  mem_select, mem_write, mem_addr, mem_data_out,
    output mem_data_in, mem_data_ready,
    input  grant, timeout_err
  );
endinterface

// File: rtl/spell_mem_arbiter.sv
// Round-robin arbiter sharing one peripheral bus between requester A (CPU) and
// requester B (debug), with a per-transaction ACCESS timeout.
module spell_mem_arbiter #(
  parameter int unsigned TIMEOUT = 8
) (
  input logic                clock,
  input logic                reset,
  spell_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND, RELEASE} state_e;
  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  owner_e     last_q, last_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0] grant_q, grant_d;
  logic       mem_select_q, mem_select_d;
  logic       mem_write_q, mem_write_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_data_q, mem_data_d;
  logic [7:0] a_data_q, a_data_d;
  logic [7:0] b_data_q, b_data_d;
  logic       a_ready_q, a_ready_d;
  logic       b_ready_q, b_ready_d;
  logic       err_q, err_d;
  logic       done;
  logic [7:0] rdata;
  logic       owner_sel;

  assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign owner_sel = (owner_q == OWN_A) ? bus.a_select : bus.b_select;

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    mem_select_d = mem_select_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    a_data_d     = a_data_q;
    b_data_d     = b_data_q;
    a_ready_d    = 1'b0;
    b_ready_d    = 1'b0;
    err_d        = 1'b0;
    done         = 1'b0;
    rdata        = 8'h00;

    unique case (state_q)
      IDLE: begin
        if (bus.a_select || bus.b_select) begin
          // A tie goes to whoever was not granted last.
          if (bus.a_select && bus.b_select) owner_d = (last_q == OWN_A) ? OWN_B : OWN_A;
          else                              owner_d = bus.a_select ? OWN_A : OWN_B;
          last_d       = owner_d;
          state_d      = ACCESS;
          cnt_d        = 8'd0;
          mem_select_d = 1'b1;
          grant_d      = (owner_d == OWN_A) ? 2'b01 : 2'b10;
          mem_addr_d   = (owner_d == OWN_A) ? bus.a_addr    : bus.b_addr;
          mem_data_d   = (owner_d == OWN_A) ? bus.a_data_in : bus.b_data_in;
          mem_write_d  = (owner_d == OWN_A) ? bus.a_write   : bus.b_write;
        end
      end

      ACCESS: begin
        cnt_d = cnt_inc;
        // Ready in the first ACCESS cycle may be left over from the previous access.
        if ((cnt_q != 8'd0) && bus.mem_data_ready) begin
          done  = 1'b1;
          rdata = bus.mem_data_in;
        end else if (cnt_inc >= TIMEOUT_C) begin
          done  = 1'b1;
          err_d = 1'b1;
        end
        if (done) begin
          state_d      = RESPOND;
          mem_select_d = 1'b0;
          if (owner_q == OWN_A) begin
            a_ready_d = 1'b1;
            a_data_d  = rdata;
          end else begin
            b_ready_d = 1'b1;
            b_data_d  = rdata;
          end
        end
      end

      RESPOND: state_d = RELEASE;

      RELEASE: begin
        if (!owner_sel) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_A;
      last_q       <= OWN_B;
      cnt_q        <= 8'd0;
      grant_q      <= 2'b00;
      mem_select_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 8'h00;
      mem_data_q   <= 8'h00;
      a_data_q     <= 8'h00;
      b_data_q     <= 8'h00;
      a_ready_q    <= 1'b0;
      b_ready_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      mem_select_q <= mem_select_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      a_data_q     <= a_data_d;
      b_data_q     <= b_data_d;
      a_ready_q    <= a_ready_d;
      b_ready_q    <= b_ready_d;
      err_q        <= err_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.mem_select   = mem_select_q;
  assign bus.mem_write    = mem_write_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data_out = mem_data_q;
  assign bus.a_data_out   = a_data_q;
  assign bus.b_data_out   = b_data_q;
  assign bus.a_data_ready = a_ready_q;
  assign bus.b_data_ready = b_ready_q;
  assign bus.timeout_err  = err_q;
endmodule
